// File: rtl/imem_prog_loader.sv
// Loads a big-endian byte stream (2-byte word count, then 4-byte words) into instruction memory from address 0.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module imem_prog_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_WORD, S_WRITE, S_DONE, S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CHK;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  localparam logic [CNT_W:0] MAX_WORDS = (CNT_W+1)'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [7:0]          len_hi_q;
  logic [CNT_W-1:0]    count_q;
  logic [31:0]         asm_q;
  logic [1:0]          byte_idx_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          chk_q;
`endif

  logic                accept;
  logic                start_ok;
  logic [CNT_W-1:0]    n_full;
  logic [CNT_W-1:0]    words_next;
  logic                last_word;

  // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready
  // depends only on state, so the source may hold or drop in_valid at any time.
  assign accept     = in_valid && in_ready;
  assign start_ok   = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign n_full     = CNT_W'({len_hi_q, in_data});
  assign words_next = words_q + CNT_W'(1);
  assign last_word  = (words_next == count_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    imem_we  = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cpu_hold = 1'b0;
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (accept) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (accept) begin
          if (n_full == '0)                      state_d = S_FINISH;
          else if ({1'b0, n_full} > MAX_WORDS)   state_d = S_ERR;
          else                                   state_d = S_WORD;
        end
      end
      S_WORD: begin
        in_ready = 1'b1;
        if (accept && byte_idx_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        imem_we = 1'b1;
        state_d = last_word ? S_FINISH : S_WORD;
      end
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) state_d = S_LEN_HI;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) state_d = S_LEN_HI;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        if (accept) state_d = (in_data == chk_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: header capture, big-endian word assembly, address/count advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi_q   <= '0;
      count_q    <= '0;
      asm_q      <= '0;
      byte_idx_q <= '0;
      addr_q     <= '0;
      words_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else if (start_ok) begin
      byte_idx_q <= '0;
      addr_q     <= '0;
      words_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_LEN_HI: if (accept) len_hi_q <= in_data;
        S_LEN_LO: if (accept) count_q  <= n_full;
        S_WORD: if (accept) begin
          asm_q      <= {asm_q[23:0], in_data};
          byte_idx_q <= byte_idx_q + 2'd1;
        end
        S_WRITE: begin
          addr_q  <= addr_q + ADDR_W'(1);
          words_q <= words_next;
        end
        default: ;
      endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (accept && state_q != S_CHK) chk_q <= chk_q ^ in_data;
`endif
    end
  end

  assign imem_addr    = addr_q;
  assign imem_wdata   = asm_q;
  assign words_loaded = words_q;

endmodule

// File: doc/imem_prog_loader.md
Name: imem_prog_loader

Overview:
- Writer side of the instruction-memory image path. The bench/CPU side reads and executes instructions from instruction memory; this block loads them.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them sequentially into instruction memory from word address 0.
- Holds the MIPS core stalled while loading and flags completion or error.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2**ADDR_W words.
- CNT_W, 16, width of the word-count header field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  instruction word.
- cpu_hold  output  1  stalls the core (PC held) while loading.
- done  output  1  load completed successfully; sticky.
- error  output  1  load aborted; sticky.
- words_loaded  output  CNT_W  number of words written so far.

Behaviour:
- Reset (async, rst_n=0): state IDLE. in_ready, imem_we, cpu_hold, done and error are 0; imem_addr, imem_wdata and words_loaded are 0.
- Reset asserted mid-load aborts immediately. No write is issued, and words already written stay in memory.
- Byte transfer happens when in_valid && in_ready at a rising edge.
- Stream format:
  - 2-byte count N, MSB first.
  - N words of 4 bytes each, MSB first, so byte0 lands in wdata[31:24].
  - With CHECKSUM_EN: 1 trailing checksum byte.
- States:
  - IDLE: in_ready=0. On start, clear done, error and words_loaded, set cpu_hold=1, go to LEN_HI.
  - LEN_HI / LEN_LO: in_ready=1; capture N[15:8], then N[7:0].
    - After LEN_LO: if N==0, go to DONE (or CHK with CHECKSUM_EN).
    - If N > 2**ADDR_W, go to ERR.
    - Otherwise go to WORD.
  - WORD: in_ready=1; shift 4 bytes into the assembly register with a 2-bit byte index. After the 4th byte, go to WRITE.
  - WRITE: in_ready=0.
    - imem_we=1 for exactly this one cycle, with imem_addr = current address and imem_wdata = assembled word.
    - On the following edge, address +1 and words_loaded +1.
    - If words_loaded+1 == N, go to DONE (or CHK); otherwise go to WORD.
  - DONE: done=1, cpu_hold=0, in_ready=0. A start pulse restarts the load.
  - ERR: error=1, cpu_hold=1 (core stays stalled), in_ready=0. A start pulse restarts the load.
- Throughput and latency:
  - With in_valid held high, each word takes 5 cycles (4 accept + 1 write).
  - imem_we rises the cycle after the 4th byte is accepted.
  - done rises the cycle after the last WRITE.
- in_valid gaps are allowed in any accepting state; no timeout.
- A start pulse during LEN_HI, LEN_LO, WORD or WRITE is ignored.
- Address never wraps. The N bound check guarantees the last address is 2**ADDR_W-1. N == 2**ADDR_W is legal.
- in_data is ignored whenever in_ready=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Extra state CHK with in_ready=1 accepts one byte.
  - A running XOR is kept over all count and word bytes.
  - If received byte == running XOR, go to DONE; otherwise go to ERR.
  - The N==0 case also passes through CHK; the checksum then covers the 2 count bytes.
- Not defined: CHK does not exist, the stream has no trailing byte, and the XOR register is not built.

Test Plan:
- Basic load: start, stream 00 02 20 08 00 05 20 09 FF FF with in_valid held high.
  - Expect imem_we pulses at addr 0 data 0x20080005 and addr 1 data 0x2009FFFF.
  - Expect in_ready low in each WRITE cycle and done=1, cpu_hold=0, words_loaded=2.
- Backpressure/gaps: same stream with in_valid toggling 1/0 each cycle → identical writes and data. No byte is duplicated or lost.
- Zero count: start, bytes 00 00 (plus checksum 00 if enabled) → no imem_we, done=1 the cycle after the last byte.
- Overflow with ADDR_W=8: count 01 01 (257) → error=1 after LEN_LO, cpu_hold stays 1, no writes. Then start with count 01 00 plus 256 words → all 256 addresses written, done=1.
- Reset mid-load: drop rst_n after 6 bytes of a 3-word load → all outputs 0 immediately, only word 0 written. Restart loads correctly from addr 0.
- With CHECKSUM_EN: header 00 01, word 12 34 56 78, checksum 0x09 → done. Checksum 0x00 → error=1.
